vproc_mem_responder: RTL and testbench
======================================

VPROC_MEM_RESPONDER -- requirements
Module: vproc_mem_responder

Interface
REQ-001 SHALL have parameter MEM_W, default 32: data width in bits; legal values are 32 and 64.
REQ-002 SHALL have parameter MEM_SZ, default 262144: capacity in bytes; a power of two.
REQ-003 SHALL have parameter MEM_LATENCY, default 1: cycles from request to response; must be >= 1.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h0: byte address of word 0; aligned to MEM_SZ.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst_ni, input, 1 bit: reset; asynchronous, active-low.
REQ-007 SHALL have port mem_req_i, input, 1 bit: request valid this cycle.
REQ-008 SHALL have port mem_addr_i, input, 32 bits: byte address.
REQ-009 SHALL have port mem_we_i, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port mem_be_i, input, MEM_W/8 bits: byte enables for writes.
REQ-011 SHALL have port mem_wdata_i, input, MEM_W bits: write data.
REQ-012 SHALL have port mem_rvalid_o, output, 1 bit: response valid.
REQ-013 SHALL have port mem_err_o, output, 1 bit: response error; qualified by mem_rvalid_o.
REQ-014 SHALL have port mem_rdata_o, output, MEM_W bits: read data; qualified by mem_rvalid_o.
REQ-015 SHALL have port prog_end_o, output, 1 bit: one-cycle pulse on a read request to address 0.

Function
REQ-016 SHALL accept every request in the cycle it is asserted; the block has no grant or backpressure, and it sustains one request per cycle.
REQ-017 SHALL assert mem_rvalid_o exactly MEM_LATENCY cycles after each accepted request, for reads and for writes alike.
REQ-018 SHALL decode an address as in-range when (mem_addr_i - BASE_ADDR) < MEM_SZ; word index = offset[$clog2(MEM_SZ)-1:$clog2(MEM_W/8)].
REQ-019 SHALL update an in-range write at the clock edge of acceptance, writing only the bytes whose mem_be_i bit is 1; a write with mem_be_i = 0 leaves memory unchanged.
REQ-020 SHALL drive the read response data from the memory contents at the acceptance edge; a read in cycle N+1 returns the data written in cycle N.
REQ-021 SHALL, for an out-of-range access, drive mem_err_o=1 with the response, mem_rdata_o=0, and discard any write.
REQ-022 SHALL drive mem_rdata_o=0 on write responses and mem_err_o=0 and mem_rdata_o=0 whenever mem_rvalid_o=0.
REQ-023 SHALL deliver back-to-back requests in order, with no drop or merge, across all latency settings.
REQ-024 SHALL register prog_end_o: it is high in the cycle after a read request with mem_addr_i == 32'h0, and low otherwise.

Reset
REQ-025 SHALL, while rst_ni=0, hold mem_rvalid_o, mem_err_o, mem_rdata_o and prog_end_o at 0.
REQ-026 SHALL flush the latency pipeline on reset; responses in flight are dropped and never emitted.
REQ-027 SHALL NOT initialise or clear memory contents on reset; contents survive reset.
REQ-028 SHALL ignore requests while rst_ni=0.

Configuration
REQ-029 SHALL, when VPROC_MEM_RESP_MISALIGN_ERR_EN is defined, treat any request with mem_addr_i[$clog2(MEM_W/8)-1:0] != 0 as an error: err=1, rdata=0, write discarded.
REQ-030 SHALL, when VPROC_MEM_RESP_MISALIGN_ERR_EN is undefined, ignore the low address bits, so misaligned accesses hit the aligned word.

Structure
REQ-031 SHALL place the response struct typedef (rvalid, err, rdata) and the MEM_W legality check constants in the shared package vproc_mem_pkg.
REQ-032 SHALL implement the latency shift register as the sub-module vproc_mem_resp_pipe, parameterised by depth MEM_LATENCY and carrying the package struct.

Verification
REQ-033 SHALL cover: LAT=1, write 0xDEADBEEF at 0x100 with be=4'hF, then read 0x100 -> write response rvalid, err=0; next response rdata=0xDEADBEEF.
REQ-034 SHALL cover: LAT=3, four back-to-back reads of 0x0, 0x4, 0x8, 0xC preloaded with 1..4 -> rvalid high for 4 consecutive cycles starting 3 cycles after the first request, with data 1, 2, 3, 4.
REQ-035 SHALL cover: word 0x11223344 at 0x20, write be=4'b0101 with data 0xAABBCCDD -> a later read returns 0x11BB33DD.
REQ-036 SHALL cover: read 0x0004_0000 with MEM_SZ=262144 -> err=1, rdata=0; write to the same address leaves memory unchanged.
REQ-037 SHALL cover: LAT=2, reset asserted one cycle after a read -> no rvalid emitted; memory contents intact after release.
REQ-038 SHALL cover: read 0x0 -> prog_end_o pulses for exactly one cycle; with the macro defined, a read of 0x102 -> err=1.

Source files
------------

// File: rtl/vproc_mem_pkg.sv
// ---------------------------------------------------------------------------
// vproc_mem_pkg
// Shared types and constants for the vproc memory responder.
//   mem_resp_t    : one response beat (rvalid, err, rdata) as it travels down
//                   the latency pipeline. rdata is sized for the widest legal
//                   data bus; narrower configurations use the low MEM_W bits.
//   MEM_W_LEGAL_* : the only data widths the responder supports.
//   memWidthLegal : elaboration-time helper to check a MEM_W value.
// ---------------------------------------------------------------------------
package vproc_mem_pkg;

    localparam int MEM_W_LEGAL_A = 32;
    localparam int MEM_W_LEGAL_B = 64;
    localparam int MEM_W_MAX     = 64;

    typedef struct packed {
        logic                 rvalid;
        logic                 err;
        logic [MEM_W_MAX-1:0] rdata;
    } mem_resp_t;

    function automatic bit memWidthLegal(input int width);
        return (width == MEM_W_LEGAL_A) || (width == MEM_W_LEGAL_B);
    endfunction

endpackage

// File: rtl/vproc_mem_resp_pipe.sv
// ---------------------------------------------------------------------------
// vproc_mem_resp_pipe
// Fixed-depth shift register that delays a response beat by DEPTH cycles.
// Reset clears every stage, so beats in flight are dropped.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   resp_i : response beat entering the pipeline this cycle
//   resp_o : response beat leaving the pipeline (DEPTH cycles later)
// ---------------------------------------------------------------------------
module vproc_mem_resp_pipe
    import vproc_mem_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  mem_resp_t resp_i,
    output mem_resp_t resp_o
);

    mem_resp_t stage_q [DEPTH];
    mem_resp_t stage_d [DEPTH];

    // Each stage takes the value of the stage in front of it; stage 0 takes
    // the freshly accepted request's response.
    always_comb begin
        stage_d[0] = resp_i;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Stage registers; reset empties the whole pipeline.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign resp_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vproc_mem_responder.sv
// ---------------------------------------------------------------------------
// vproc_mem_responder
// Simulation-style memory responder for a vector processor bus. Accepts one
// request per cycle with no backpressure and answers each one exactly
// MEM_LATENCY cycles later. Writes land at the acceptance edge with byte
// enables; reads sample the array at the acceptance edge. Accesses outside
// [BASE_ADDR, BASE_ADDR+MEM_SZ) answer with err=1 and never modify memory.
// Memory contents are not touched by reset.
//
// Optional feature macro: VPROC_MEM_RESP_MISALIGN_ERR_EN
//   defined   : any access with nonzero low address bits answers err=1 and
//               writes are discarded.
//   undefined : low address bits are ignored (misaligned hits aligned word).
//
// Ports:
//   clk_i        : clock, rising edge
//   rst_ni       : asynchronous active-low reset
//   mem_req_i    : request valid this cycle
//   mem_addr_i   : byte address
//   mem_we_i     : 1 = write, 0 = read
//   mem_be_i     : write byte enables
//   mem_wdata_i  : write data
//   mem_rvalid_o : response valid
//   mem_err_o    : response error (qualified by mem_rvalid_o)
//   mem_rdata_o  : read data (qualified by mem_rvalid_o, 0 for writes)
//   prog_end_o   : one-cycle pulse the cycle after a read of address 0
// ---------------------------------------------------------------------------
module vproc_mem_responder
    import vproc_mem_pkg::*;
#(
    parameter int          MEM_W       = 32,
    parameter int          MEM_SZ      = 262144,
    parameter int          MEM_LATENCY = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               mem_req_i,
    input  logic [31:0]        mem_addr_i,
    input  logic               mem_we_i,
    input  logic [MEM_W/8-1:0] mem_be_i,
    input  logic [MEM_W-1:0]   mem_wdata_i,
    output logic               mem_rvalid_o,
    output logic               mem_err_o,
    output logic [MEM_W-1:0]   mem_rdata_o,
    output logic               prog_end_o
);

    localparam int NB     = MEM_W / 8;
    localparam int BW     = $clog2(NB);
    localparam int AW     = $clog2(MEM_SZ);
    localparam int NWORDS = MEM_SZ / NB;

    if (!memWidthLegal(MEM_W)) begin : gBadWidth
        $error("vproc_mem_responder: MEM_W must be 32 or 64");
    end
    if (MEM_LATENCY < 1) begin : gBadLatency
        $error("vproc_mem_responder: MEM_LATENCY must be at least 1");
    end

    logic [MEM_W-1:0] mem_q [NWORDS];

    logic [31:0]    offset;
    logic [AW-BW-1:0] wordIdx;
    logic           inRange;
    logic           misaligned;
    logic           accessOk;
    mem_resp_t      respIn;
    mem_resp_t      respOut;
    logic           progEnd_q;
    logic           progEnd_d;
    logic           unusedRdata;

    // Address decode. The offset is computed with wrap-around so addresses
    // below BASE_ADDR become huge and fall out of range naturally.
    always_comb begin
        offset     = mem_addr_i - BASE_ADDR;
        inRange    = offset < 32'(MEM_SZ);
        wordIdx    = offset[AW-1:BW];
`ifdef VPROC_MEM_RESP_MISALIGN_ERR_EN
        misaligned = |mem_addr_i[BW-1:0];
`else
        misaligned = 1'b0;
`endif
        accessOk   = inRange & ~misaligned;
    end

    // Memory array write port. The reset branch is deliberately empty: reset
    // only blocks writes, it never clears the contents.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
        end else if (mem_req_i && mem_we_i && accessOk) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_be_i[b]) begin
                    mem_q[wordIdx][b*8 +: 8] <= mem_wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Build the response beat for the request accepted this cycle. Read data
    // comes from the array before this edge's write, and is forced to zero for
    // writes and errors so the pipeline never carries stale data.
    always_comb begin
        respIn    = '0;
        progEnd_d = 1'b0;
        if (mem_req_i) begin
            respIn.rvalid = 1'b1;
            respIn.err    = ~accessOk;
            if (!mem_we_i && accessOk) begin
                respIn.rdata[MEM_W-1:0] = mem_q[wordIdx];
            end
            progEnd_d = ~mem_we_i & (mem_addr_i == 32'h0);
        end
    end

    vproc_mem_resp_pipe #(
        .DEPTH (MEM_LATENCY)
    ) u_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .resp_i (respIn),
        .resp_o (respOut)
    );

    // Program-end marker, registered so it lines up one cycle after the read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            progEnd_q <= 1'b0;
        end else begin
            progEnd_q <= progEnd_d;
        end
    end

    // Output qualification keeps err/rdata at zero whenever no response is out.
    assign mem_rvalid_o = respOut.rvalid;
    assign mem_err_o    = respOut.rvalid & respOut.err;
    assign mem_rdata_o  = respOut.rvalid ? respOut.rdata[MEM_W-1:0] : '0;
    assign prog_end_o   = progEnd_q;
    assign unusedRdata  = ^respOut.rdata;

endmodule

// File: tb/tb_vproc_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_vproc_mem_responder
// Directed bench driving three responders (latency 1, 2, 3) from one shared
// request stream. Inputs change on the falling edge; outputs are sampled on
// the falling edge, half a cycle after the accepting rising edge.
// ---------------------------------------------------------------------------
module tb_vproc_mem_responder;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        mem_req_i;
    logic [31:0] mem_addr_i;
    logic        mem_we_i;
    logic [3:0]  mem_be_i;
    logic [31:0] mem_wdata_i;

    logic        rv1, rv2, rv3;
    logic        err1, err2, err3;
    logic [31:0] rd1, rd2, rd3;
    logic        pe1, pe2, pe3;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    vproc_mem_responder #(.MEM_W(32), .MEM_SZ(262144), .MEM_LATENCY(1), .BASE_ADDR(32'h0)) u_lat1 (
        .clk_i(clk), .rst_ni(rst_ni), .mem_req_i(mem_req_i), .mem_addr_i(mem_addr_i),
        .mem_we_i(mem_we_i), .mem_be_i(mem_be_i), .mem_wdata_i(mem_wdata_i),
        .mem_rvalid_o(rv1), .mem_err_o(err1), .mem_rdata_o(rd1), .prog_end_o(pe1));

    vproc_mem_responder #(.MEM_W(32), .MEM_SZ(262144), .MEM_LATENCY(2), .BASE_ADDR(32'h0)) u_lat2 (
        .clk_i(clk), .rst_ni(rst_ni), .mem_req_i(mem_req_i), .mem_addr_i(mem_addr_i),
        .mem_we_i(mem_we_i), .mem_be_i(mem_be_i), .mem_wdata_i(mem_wdata_i),
        .mem_rvalid_o(rv2), .mem_err_o(err2), .mem_rdata_o(rd2), .prog_end_o(pe2));

    vproc_mem_responder #(.MEM_W(32), .MEM_SZ(262144), .MEM_LATENCY(3), .BASE_ADDR(32'h0)) u_lat3 (
        .clk_i(clk), .rst_ni(rst_ni), .mem_req_i(mem_req_i), .mem_addr_i(mem_addr_i),
        .mem_we_i(mem_we_i), .mem_be_i(mem_be_i), .mem_wdata_i(mem_wdata_i),
        .mem_rvalid_o(rv3), .mem_err_o(err3), .mem_rdata_o(rd3), .prog_end_o(pe3));

    // Drive one cycle's worth of request inputs.
    task automatic applyStimulus(input logic req, input logic we, input logic [31:0] addr,
                                 input logic [3:0] be, input logic [31:0] wd);
        mem_req_i   = req;
        mem_we_i    = we;
        mem_addr_i  = addr;
        mem_be_i    = be;
        mem_wdata_i = wd;
    endtask

    task automatic idleCycles(input int n);
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (n) @(negedge clk);
    endtask

    // Outputs must stay at zero during reset even with a request presented.
    task automatic test_reset();
        rst_ni = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (3) @(negedge clk);
        nChecks++; if (rv1 !== 1'b0) begin nFails++; $display("[TB] FAIL reset_rv1: got %0b expected 0", rv1); end
        nChecks++; if (rv2 !== 1'b0) begin nFails++; $display("[TB] FAIL reset_rv2: got %0b expected 0", rv2); end
        nChecks++; if (rv3 !== 1'b0) begin nFails++; $display("[TB] FAIL reset_rv3: got %0b expected 0", rv3); end
        nChecks++; if (err1 !== 1'b0) begin nFails++; $display("[TB] FAIL reset_err1: got %0b expected 0", err1); end
        nChecks++; if (rd1 !== 32'h0) begin nFails++; $display("[TB] FAIL reset_rd1: got %h expected 0", rd1); end
        nChecks++; if (pe1 !== 1'b0) begin nFails++; $display("[TB] FAIL reset_pe1: got %0b expected 0", pe1); end
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        rst_ni = 1'b1;
        @(negedge clk);
    endtask

    // Write then immediately read the same word.
    task automatic test_write_read();
        applyStimulus(1'b1, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        nChecks++; if (rv1 !== 1'b1) begin nFails++; $display("[TB] FAIL wr_rv1: got %0b expected 1", rv1); end
        nChecks++; if (err1 !== 1'b0) begin nFails++; $display("[TB] FAIL wr_err1: got %0b expected 0", err1); end
        nChecks++; if (rd1 !== 32'h0) begin nFails++; $display("[TB] FAIL wr_rd1: got %h expected 0", rd1); end
        nChecks++; if (rv2 !== 1'b0) begin nFails++; $display("[TB] FAIL wr_rv2_early: got %0b expected 0", rv2); end
        applyStimulus(1'b1, 1'b0, 32'h100, 4'h0, 32'h0);
        @(negedge clk);
        nChecks++; if (rv1 !== 1'b1) begin nFails++; $display("[TB] FAIL rd_rv1: got %0b expected 1", rv1); end
        nChecks++; if (rd1 !== 32'hDEADBEEF) begin nFails++; $display("[TB] FAIL rd_rd1: got %h expected deadbeef", rd1); end
        nChecks++; if (rv2 !== 1'b1) begin nFails++; $display("[TB] FAIL wr_rv2: got %0b expected 1", rv2); end
        nChecks++; if (rd2 !== 32'h0) begin nFails++; $display("[TB] FAIL wr_rd2: got %h expected 0", rd2); end
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        nChecks++; if (rv1 !== 1'b0) begin nFails++; $display("[TB] FAIL idle_rv1: got %0b expected 0", rv1); end
        nChecks++; if (rd1 !== 32'h0) begin nFails++; $display("[TB] FAIL idle_rd1: got %h expected 0", rd1); end
        nChecks++; if (err1 !== 1'b0) begin nFails++; $display("[TB] FAIL idle_err1: got %0b expected 0", err1); end
        nChecks++; if (rd2 !== 32'hDEADBEEF) begin nFails++; $display("[TB] FAIL rd_rd2: got %h expected deadbeef", rd2); end
        idleCycles(3);
    endtask

    // Four consecutive reads observed through the latency-3 responder.
    task automatic test_back_to_back();
        logic        expV;
        logic [31:0] expD;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 32'(4 * i), 4'hF, 32'(i + 1));
            @(negedge clk);
        end
        idleCycles(4);
        for (int t = 0; t < 8; t++) begin
            if (t < 4) applyStimulus(1'b1, 1'b0, 32'(4 * t), 4'h0, 32'h0);
            else       applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            @(negedge clk);
            expV = (t + 1 >= 3) && (t + 1 <= 6);
            expD = expV ? 32'(t - 1) : 32'h0;
            nChecks++; if (rv3 !== expV) begin nFails++; $display("[TB] FAIL b2b_rv3[%0d]: got %0b expected %0b", t + 1, rv3, expV); end
            nChecks++; if (rd3 !== expD) begin nFails++; $display("[TB] FAIL b2b_rd3[%0d]: got %h expected %h", t + 1, rd3, expD); end
        end
        idleCycles(2);
    endtask

    // Partial writes, including an all-zero byte enable.
    task automatic test_byte_enable();
        applyStimulus(1'b1, 1'b1, 32'h20, 4'hF, 32'h11223344);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
        @(negedge clk);
        nChecks++; if (rd1 !== 32'h11BB33DD) begin nFails++; $display("[TB] FAIL be_rd1: got %h expected 11bb33dd", rd1); end
        nChecks++; if (err1 !== 1'b0) begin nFails++; $display("[TB] FAIL be_err1: got %0b expected 0", err1); end
        idleCycles(3);
    endtask

    // Just past the top of memory, and the last valid word.
    task automatic test_out_of_range();
        applyStimulus(1'b1, 1'b0, 32'h0004_0000, 4'h0, 32'h0);
        @(negedge clk);
        nChecks++; if (rv1 !== 1'b1) begin nFails++; $display("[TB] FAIL oor_rd_rv1: got %0b expected 1", rv1); end
        nChecks++; if (err1 !== 1'b1) begin nFails++; $display("[TB] FAIL oor_rd_err1: got %0b expected 1", err1); end
        nChecks++; if (rd1 !== 32'h0) begin nFails++; $display("[TB] FAIL oor_rd_rd1: got %h expected 0", rd1); end
        applyStimulus(1'b1, 1'b1, 32'h0004_0000, 4'hF, 32'hCAFEF00D);
        @(negedge clk);
        nChecks++; if (err1 !== 1'b1) begin nFails++; $display("[TB] FAIL oor_wr_err1: got %0b expected 1", err1); end
        applyStimulus(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        nChecks++; if (rd1 !== 32'h1) begin nFails++; $display("[TB] FAIL oor_wr_discard: got %h expected 1", rd1); end
        nChecks++; if (err1 !== 1'b0) begin nFails++; $display("[TB] FAIL oor_w0_err1: got %0b expected 0", err1); end
        applyStimulus(1'b1, 1'b1, 32'h0003_FFFC, 4'hF, 32'h12345678);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h0003_FFFC, 4'h0, 32'h0);
        @(negedge clk);
        nChecks++; if (err1 !== 1'b0) begin nFails++; $display("[TB] FAIL top_err1: got %0b expected 0", err1); end
        nChecks++; if (rd1 !== 32'h12345678) begin nFails++; $display("[TB] FAIL top_rd1: got %h expected 12345678", rd1); end
        idleCycles(3);
    endtask

    // prog_end pulse only on a read of address zero.
    task automatic test_prog_end();
        applyStimulus(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        nChecks++; if (pe1 !== 1'b1) begin nFails++; $display("[TB] FAIL pe_pulse1: got %0b expected 1", pe1); end
        nChecks++; if (pe3 !== 1'b1) begin nFails++; $display("[TB] FAIL pe_pulse3: got %0b expected 1", pe3); end
        applyStimulus(1'b1, 1'b1, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        nChecks++; if (pe1 !== 1'b0) begin nFails++; $display("[TB] FAIL pe_one_cycle: got %0b expected 0", pe1); end
        applyStimulus(1'b1, 1'b0, 32'h4, 4'h0, 32'h0);
        @(negedge clk);
        nChecks++; if (pe1 !== 1'b0) begin nFails++; $display("[TB] FAIL pe_after_write0: got %0b expected 0", pe1); end
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        nChecks++; if (pe1 !== 1'b0) begin nFails++; $display("[TB] FAIL pe_after_read4: got %0b expected 0", pe1); end
        idleCycles(3);
    endtask

    // Misaligned reads: error with the feature, aligned word without it.
    task automatic test_misalign();
        logic        expErr;
        logic [31:0] expD;
`ifdef VPROC_MEM_RESP_MISALIGN_ERR_EN
        expErr = 1'b1;
        expD   = 32'h0;
`else
        expErr = 1'b0;
        expD   = 32'hDEADBEEF;
`endif
        applyStimulus(1'b1, 1'b0, 32'h102, 4'h0, 32'h0);
        @(negedge clk);
        nChecks++; if (rv1 !== 1'b1) begin nFails++; $display("[TB] FAIL mis_rv1: got %0b expected 1", rv1); end
        nChecks++; if (err1 !== expErr) begin nFails++; $display("[TB] FAIL mis_err1: got %0b expected %0b", err1, expErr); end
        nChecks++; if (rd1 !== expD) begin nFails++; $display("[TB] FAIL mis_rd1: got %h expected %h", rd1, expD); end
        idleCycles(3);
    endtask

    // Reset one cycle after a read drops the in-flight response; memory survives.
    task automatic test_reset_flush();
        applyStimulus(1'b1, 1'b1, 32'h300, 4'hF, 32'h55);
        @(negedge clk);
        idleCycles(3);
        applyStimulus(1'b1, 1'b0, 32'h300, 4'h0, 32'h0);
        @(negedge clk);
        rst_ni = 1'b0;
        applyStimulus(1'b1, 1'b1, 32'h300, 4'hF, 32'h66);
        #1;
        nChecks++; if (rv1 !== 1'b0) begin nFails++; $display("[TB] FAIL rst_async_rv1: got %0b expected 0", rv1); end
        nChecks++; if (rd1 !== 32'h0) begin nFails++; $display("[TB] FAIL rst_async_rd1: got %h expected 0", rd1); end
        @(negedge clk);
        nChecks++; if (rv2 !== 1'b0) begin nFails++; $display("[TB] FAIL rst_rv2: got %0b expected 0", rv2); end
        @(negedge clk);
        nChecks++; if (rv3 !== 1'b0) begin nFails++; $display("[TB] FAIL rst_rv3: got %0b expected 0", rv3); end
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        rst_ni = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            nChecks++; if (rv2 !== 1'b0) begin nFails++; $display("[TB] FAIL flush_rv2[%0d]: got %0b expected 0", t, rv2); end
            nChecks++; if (rv3 !== 1'b0) begin nFails++; $display("[TB] FAIL flush_rv3[%0d]: got %0b expected 0", t, rv3); end
        end
        applyStimulus(1'b1, 1'b0, 32'h300, 4'h0, 32'h0);
        @(negedge clk);
        nChecks++; if (rv1 !== 1'b1) begin nFails++; $display("[TB] FAIL keep_rv1: got %0b expected 1", rv1); end
        nChecks++; if (rd1 !== 32'h55) begin nFails++; $display("[TB] FAIL keep_rd1: got %h expected 00000055", rd1); end
        applyStimulus(1'b1, 1'b0, 32'h100, 4'h0, 32'h0);
        @(negedge clk);
        nChecks++; if (rd1 !== 32'hDEADBEEF) begin nFails++; $display("[TB] FAIL keep_rd100: got %h expected deadbeef", rd1); end
        idleCycles(3);
    endtask

    initial begin
        rst_ni = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        test_reset();
        test_write_read();
        test_back_to_back();
        test_byte_enable();
        test_out_of_range();
        test_prog_end();
        test_misalign();
        test_reset_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
